decoder_3to8: RTL and testbench

//   Registered 3-to-8 line decoder with active-high enable.

---
 rtl/decoder_3to8_if.sv | 13 +
 rtl/decoder_3to8.sv | 36 +++
 tb/tb_decoder_3to8.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/decoder_3to8_if.sv
// Select/enable bus feeding the registered 3-to-8 decoder.
// The master drives the enable and select code; the decoder returns
// the one-hot word on Y.
interface decoder_3to8_if #(
  parameter int SEL_W = 3
);
  logic                     E;
  logic [SEL_W-1:0]         s;
  logic [(1 << SEL_W)-1:0]  Y;

  modport master (output E, output s, input  Y);
  modport slave  (input  E, input  s, output Y);
endinterface

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder with active-high enable.
// Turns the select code into a one-hot word one clock later; used for
// register-select and write-enable fan-out. The Y register is the only
// state, and the asynchronous reset clears it without waiting for a clock.
module decoder_3to8 #(
  parameter int                      SEL_W   = 3,
  parameter logic [(1<<SEL_W)-1:0]   Y_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  decoder_3to8_if.slave   bus
);
  localparam int Y_W = 1 << SEL_W;

  logic [Y_W-1:0] y_next;

  // Decode a select code into a word with exactly one bit set.
  function automatic logic [Y_W-1:0] one_hot(input logic [SEL_W-1:0] code);
    logic [Y_W-1:0] r;
    r       = '0;
    r[code] = 1'b1;
    return r;
  endfunction

  // Next output: the decoded line when enabled, no line when disabled.
  always_comb begin
    y_next = '0;
    if (bus.E) y_next = one_hot(bus.s);
  end

  // Output register; reset discards whatever input is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.Y <= Y_RESET;
    else        bus.Y <= y_next;
  end
endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: reset behaviour, table sweep of
// all enable/select combinations, hand-written multi-cycle corner cases,
// and randomized stimulus against a behavioural model.
module tb_decoder_3to8;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  decoder_3to8_if bus ();

  decoder_3to8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       e;
    logic [2:0] s;
    logic [7:0] y;
  } vec_t;

  vec_t vecs [16];

  // Behavioural model: bit number s lit when enabled, nothing otherwise.
  function automatic logic [7:0] ref_y(input logic e, input logic [2:0] sel);
    int v;
    v = e ? (2 ** int'(sel)) : 0;
    return v[7:0];
  endfunction

  function automatic bit is_one_hot(input logic [7:0] y);
    int v;
    v = int'(y);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: Y=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_one_hot(input string name, input logic [7:0] act);
    tests++;
    if (!is_one_hot(act)) begin
      fails++;
      $display("FAIL %s: Y=%h expected one-hot at %0t", name, act, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] sel);
    bus.E = e;
    bus.s = sel;
  endtask

  initial begin
    logic [7:0] exp_y;
    logic [2:0] seq [4];
    logic       re;
    logic [2:0] rs;

    tests = 0;
    fails = 0;

    vecs[0]  = '{1'b0, 3'd0, 8'h00};
    vecs[1]  = '{1'b0, 3'd1, 8'h00};
    vecs[2]  = '{1'b0, 3'd2, 8'h00};
    vecs[3]  = '{1'b0, 3'd3, 8'h00};
    vecs[4]  = '{1'b0, 3'd4, 8'h00};
    vecs[5]  = '{1'b0, 3'd5, 8'h00};
    vecs[6]  = '{1'b0, 3'd6, 8'h00};
    vecs[7]  = '{1'b0, 3'd7, 8'h00};
    vecs[8]  = '{1'b1, 3'd0, 8'h01};
    vecs[9]  = '{1'b1, 3'd1, 8'h02};
    vecs[10] = '{1'b1, 3'd2, 8'h04};
    vecs[11] = '{1'b1, 3'd3, 8'h08};
    vecs[12] = '{1'b1, 3'd4, 8'h10};
    vecs[13] = '{1'b1, 3'd5, 8'h20};
    vecs[14] = '{1'b1, 3'd6, 8'h40};
    vecs[15] = '{1'b1, 3'd7, 8'h80};

    // Reset asserted without any clock edge, with the decoder enabled.
    rst_n = 1'b1;
    drive(1'b1, 3'd5);
    #1;
    rst_n = 1'b0;
    #2;
    check("reset_async", bus.Y, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_held", bus.Y, 8'h00);
    end
    rst_n = 1'b1;

    // Exhaustive sweep, one vector per clock.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].e, vecs[i].s);
      step();
      check($sformatf("sweep_%0d", i), bus.Y, vecs[i].y);
    end

    // Latency: input changed mid-cycle must not show until the next edge.
    drive(1'b0, 3'd0);
    step();
    check("lat_pre", bus.Y, 8'h00);
    #3;
    drive(1'b1, 3'd3);
    #2;
    check("lat_hold", bus.Y, 8'h00);
    step();
    check("lat_edge", bus.Y, 8'h08);

    // Enable drop with select unchanged.
    drive(1'b1, 3'd7);
    step();
    check("en_on", bus.Y, 8'h80);
    drive(1'b0, 3'd7);
    step();
    check("en_drop", bus.Y, 8'h00);

    // Reset between edges clears at once; release resumes at next edge.
    drive(1'b1, 3'd6);
    step();
    check("mid_pre", bus.Y, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", bus.Y, 8'h00);
    drive(1'b1, 3'd1);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_release_hold", bus.Y, 8'h00);
    step();
    check("mid_release", bus.Y, 8'h02);

    // Back-to-back alternating codes.
    seq[0] = 3'd0; seq[1] = 3'd7; seq[2] = 3'd0; seq[3] = 3'd7;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i]);
      step();
      check($sformatf("b2b_%0d", i), bus.Y, (seq[i] == 3'd0) ? 8'h01 : 8'h80);
      check_one_hot($sformatf("b2b_onehot_%0d", i), bus.Y);
    end

    // Randomized stimulus against the model.
    for (int i = 0; i < 300; i++) begin
      re = 1'($urandom_range(0, 3) != 0);
      rs = 3'($urandom_range(0, 7));
      drive(re, rs);
      exp_y = ref_y(re, rs);
      step();
      check($sformatf("rand_%0d", i), bus.Y, exp_y);
      if (re) check_one_hot($sformatf("rand_onehot_%0d", i), bus.Y);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
